// File: rtl/load_controller.sv
// Sequence-buffer load controller: accepts NUM_BUFF_REGS query/database word pairs,
// launches the scoring matrix, and supervises its completion with a cycle timeout.
module load_controller #(
   parameter int NUM_BUFF_REGS = 8,
   parameter int BUFF_CNT_W    = 3,
   parameter int CALC_TIMEOUT  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  wr_en_buff,
   output logic [BUFF_CNT_W-1:0] count,
   output logic                  calc_start,
   input  logic                  calc_done,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err
);

   localparam int CYC_W = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CALC = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [BUFF_CNT_W-1:0] CNT_LAST = BUFF_CNT_W'(NUM_BUFF_REGS - 1);
   localparam logic [CYC_W-1:0]      CYC_LAST = CYC_W'(CALC_TIMEOUT - 1);

   logic [1:0]            state_q,       state_d;
   logic [BUFF_CNT_W-1:0] count_q,       count_d;
   logic [CYC_W-1:0]      cyc_q,         cyc_d;
   logic                  timeout_err_q, timeout_err_d;
   logic                  in_ready_q,    in_ready_d;
   logic                  calc_start_q,  calc_start_d;
   logic                  busy_q,        busy_d;
   logic                  done_q,        done_d;
   logic                  accept_s;
   logic                  calc_done_s;

   assign accept_s    = in_valid & in_ready_q;
   // A calc_done already high during the launch cycle belongs to a previous run.
   assign calc_done_s = calc_done & ~calc_start_q;

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      cyc_d         = cyc_q;
      timeout_err_d = timeout_err_q;
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         count_d = {BUFF_CNT_W{1'b0}};
         cyc_d   = {CYC_W{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d       = S_LOAD;
                  count_d       = {BUFF_CNT_W{1'b0}};
                  timeout_err_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_LOAD: begin
               if (accept_s) begin
                  if (count_q == CNT_LAST) begin
                     state_d = S_CALC;
                     count_d = {BUFF_CNT_W{1'b0}};
                     cyc_d   = {CYC_W{1'b0}};
                  end else begin
                     count_d = count_q + BUFF_CNT_W'(1);
                  end
               end else begin
                  count_d = count_q;
               end
            end
            S_CALC: begin
               if (calc_done_s) begin
                  state_d = S_DONE;
               end else if (cyc_q == CYC_LAST) begin
                  state_d       = S_IDLE;
                  timeout_err_d = 1'b1;
               end else begin
                  cyc_d = cyc_q + CYC_W'(1);
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               count_d = {BUFF_CNT_W{1'b0}};
               cyc_d   = {CYC_W{1'b0}};
            end
         endcase
      end
   end

   // Output flags are decoded from the next state so they are registered yet cycle-aligned.
   always_comb begin
      in_ready_d   = (state_d == S_LOAD);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
      calc_start_d = (state_d == S_CALC) && (state_q != S_CALC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         count_q       <= {BUFF_CNT_W{1'b0}};
         cyc_q         <= {CYC_W{1'b0}};
         timeout_err_q <= 1'b0;
         in_ready_q    <= 1'b0;
         calc_start_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         cyc_q         <= cyc_d;
         timeout_err_q <= timeout_err_d;
         in_ready_q    <= in_ready_d;
         calc_start_q  <= calc_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign wr_en_buff  = accept_s;
   assign count       = count_q;
   assign calc_start  = calc_start_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_load_controller.sv
// Directed testbench for load_controller (8 buffer words, 16-cycle calc timeout).
module tb_load_controller;

   logic       clk = 1'b0;
   logic       rst, start, abort, in_valid, calc_done;
   logic       in_ready, wr_en_buff, calc_start, busy, done, timeout_err;
   logic [2:0] count;
   int         tests_run    = 0;
   int         tests_failed = 0;

   load_controller #(.NUM_BUFF_REGS(8), .BUFF_CNT_W(3), .CALC_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
      .in_ready(in_ready), .wr_en_buff(wr_en_buff), .count(count),
      .calc_start(calc_start), .calc_done(calc_done), .busy(busy),
      .done(done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a job and streams 8 back-to-back words; returns in the calc_start cycle.
   task automatic run_load(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         #1;
         tests_run++;
         if (count !== 3'(i) || wr_en_buff !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_load[%0d]: count=%0d wr_en=%b, expected count=%0d wr_en=1", tag, i, count, wr_en_buff, i);
         end
         tick();
      end
      in_valid = 1'b0;
      tests_run++;
      if (calc_start !== 1'b1 || in_ready !== 1'b0 || count !== 3'd0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_calc_entry: calc_start=%b in_ready=%b count=%0d busy=%b, expected 1 0 0 1", tag, calc_start, in_ready, count, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b1; calc_done = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({in_ready, wr_en_buff, calc_start, busy, done, timeout_err} !== 6'b0 || count !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset: rdy/wr/cs/busy/done/terr=%b count=%0d, expected 000000 count=0",
                  {in_ready, wr_en_buff, calc_start, busy, done, timeout_err}, count);
      end
      rst = 1'b0; in_valid = 1'b0;
      tick();
   endtask

   task automatic test_nominal();
      start = 1'b1;
      #1;
      tests_run++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL nominal_idle: busy=%b in_ready=%b, expected 0 0", busy, in_ready);
      end
      start = 1'b0;
      run_load("nominal");
      for (int k = 1; k <= 4; k++) begin
         tick();
         tests_run++;
         if (calc_start !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL nominal_calc[%0d]: calc_start=%b done=%b busy=%b, expected 0 0 1", k, calc_start, done, busy);
         end
      end
      tick();
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL nominal_done: done=%b busy=%b terr=%b, expected 1 1 0", done, busy, timeout_err);
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL nominal_idle_after: done=%b busy=%b, expected 0 0", done, busy);
      end
   endtask

   // Gapped words with calc_done held high during load and start pulsed during CALC.
   task automatic test_stall_corner();
      start = 1'b1;
      calc_done = 1'b1;
      tick();
      start = 1'b0;
      for (int w = 0; w < 8; w++) begin
         in_valid = 1'b1;
         #1;
         tests_run++;
         if (count !== 3'(w) || wr_en_buff !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_accept[%0d]: count=%0d wr_en=%b in_ready=%b, expected %0d 1 1", w, count, wr_en_buff, in_ready, w);
         end
         tick();
         in_valid = 1'b0;
         if (w < 7) begin
            for (int g = 0; g < 2; g++) begin
               #1;
               tests_run++;
               if (count !== 3'(w + 1) || wr_en_buff !== 1'b0 || in_ready !== 1'b1) begin
                  tests_failed++;
                  $display("FAIL stall_gap[%0d.%0d]: count=%0d wr_en=%b in_ready=%b, expected %0d 0 1", w, g, count, wr_en_buff, in_ready, w + 1);
               end
               tick();
            end
         end
      end
      tests_run++;
      if (calc_start !== 1'b1 || in_ready !== 1'b0 || count !== 3'd0) begin
         tests_failed++;
         $display("FAIL stall_calc_entry: calc_start=%b in_ready=%b count=%0d, expected 1 0 0", calc_start, in_ready, count);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b1 || calc_start !== 1'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL corner_launch_cycle: done=%b busy=%b cs=%b rdy=%b, expected 0 1 0 0", done, busy, calc_start, in_ready);
      end
      tick();
      calc_done = 1'b0;
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++;
         $display("FAIL corner_done: done=%b, expected 1", done);
      end
      tick();
      tests_run++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL corner_start_ignored: busy=%b in_ready=%b, expected 0 0", busy, in_ready);
      end
   endtask

   task automatic test_timeout();
      run_load("timeout");
      for (int k = 1; k <= 15; k++) begin
         tick();
         tests_run++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_calc[%0d]: busy=%b done=%b, expected 1 0", k, busy, done);
         end
      end
      tick();
      tests_run++;
      if (busy !== 1'b0 || timeout_err !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_exit: busy=%b terr=%b done=%b, expected 0 1 0", busy, timeout_err, done);
      end
      tick();
      tests_run++;
      if (timeout_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_sticky: terr=%b, expected 1", timeout_err);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (timeout_err !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_clear: terr=%b busy=%b rdy=%b, expected 0 1 1", timeout_err, busy, in_ready);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_coincide();
      run_load("coincide");
      for (int k = 1; k <= 15; k++) tick();
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      tests_run++;
      if (done !== 1'b1 || timeout_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL coincide: done=%b terr=%b, expected 1 0", done, timeout_err);
      end
      tick();
   endtask

   task automatic test_abort();
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      abort = 1'b1;
      #1;
      tests_run++;
      if (count !== 3'd4 || wr_en_buff !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_cycle: count=%0d wr_en=%b, expected 4 1", count, wr_en_buff);
      end
      tick();
      abort = 1'b0;
      in_valid = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_idle: busy=%b count=%0d rdy=%b done=%b terr=%b, expected 0 0 0 0 0", busy, count, in_ready, done, timeout_err);
      end
      run_load("after_abort");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || calc_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_calc: busy=%b done=%b cs=%b, expected 0 0 0", busy, done, calc_start);
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      tests_run++;
      if ({in_ready, calc_start, busy, done, timeout_err} !== 5'b0 || count !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_load: rdy/cs/busy/done/terr=%b count=%0d, expected 00000 0", {in_ready, calc_start, busy, done, timeout_err}, count);
      end
      run_load("after_reset");
      rst = 1'b1;
      calc_done = 1'b1;
      abort = 1'b1;
      tick();
      rst = 1'b0;
      calc_done = 1'b0;
      abort = 1'b0;
      tests_run++;
      if ({in_ready, calc_start, busy, done, timeout_err} !== 5'b0 || count !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_calc: rdy/cs/busy/done/terr=%b count=%0d, expected 00000 0", {in_ready, calc_start, busy, done, timeout_err}, count);
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || calc_start !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_no_pulse: done=%b cs=%b busy=%b, expected 0 0 0", done, calc_start, busy);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_stall_corner();
      test_timeout();
      test_coincide();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
